// File: rtl/divider.sv
// Sequential radix-2 non-restoring integer divider, signed or unsigned.
// start/busy/done handshake; results and flags hold until the next operation completes.
module divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int unsigned AW = WIDTH + 1;
  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_CORR,
    S_SIGN,
    S_DONE
  } state_t;

  state_t           state;
  logic [AW-1:0]    a;
  logic [WIDTH-1:0] q;
  logic [AW-1:0]    m;
  logic [CW-1:0]    cnt;
  logic             sx;
  logic             sy;
  logic             sop;
  logic             dz;
  logic [WIDTH-1:0] xr;
  logic [WIDTH-1:0] yr;

  logic [AW-1:0]    a_sh;
  logic [AW-1:0]    a_step;
  logic [WIDTH-1:0] x_mag;
  logic [WIDTH-1:0] y_mag;
  logic [WIDTH-1:0] q_signed;
  logic [WIDTH-1:0] r_signed;

  // Datapath: one non-restoring step, operand magnitudes and final sign fix-up
  always_comb begin
    a_sh     = {a[WIDTH-1:0], q[WIDTH-1]};
    a_step   = a[WIDTH] ? (a_sh + m) : (a_sh - m);
    x_mag    = (sop && xr[WIDTH-1]) ? -xr : xr;
    y_mag    = (sop && yr[WIDTH-1]) ? -yr : yr;
    q_signed = (sx ^ sy) ? -q : q;
    r_signed = sx ? -a[WIDTH-1:0] : a[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      a           <= '0;
      q           <= '0;
      m           <= '0;
      cnt         <= '0;
      sx          <= 1'b0;
      sy          <= 1'b0;
      sop         <= 1'b0;
      dz          <= 1'b0;
      xr          <= '0;
      yr          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            xr    <= X;
            yr    <= Y;
            sop   <= signed_op;
            busy  <= 1'b1;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          sx <= sop & xr[WIDTH-1];
          sy <= sop & yr[WIDTH-1];
          if (yr == '0) begin
            // Zero divisor skips iteration but keeps the same exit path
            dz    <= 1'b1;
            state <= S_SIGN;
          end else begin
            dz    <= 1'b0;
            q     <= x_mag;
            m     <= {1'b0, y_mag};
            a     <= '0;
            cnt   <= '0;
            state <= S_ITER;
          end
        end
        S_ITER: begin
          a   <= a_step;
          q   <= {q[WIDTH-2:0], ~a_step[WIDTH]};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state <= S_CORR;
          end
        end
        S_CORR: begin
          if (a[WIDTH]) begin
            a <= a + m;
          end
          state <= S_SIGN;
        end
        S_SIGN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_DONE;
          if (dz) begin
            quotient    <= ALL_ONES;
            remainder   <= xr;
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
          end else begin
            // Most-negative / -1 wraps naturally to most-negative with zero remainder
            quotient    <= q_signed;
            remainder   <= r_signed;
            div_by_zero <= 1'b0;
            overflow    <= sop && (xr == MIN_NEG) && (yr == ALL_ONES);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Randomized scoreboard bench for divider: reference model pushes expectations,
// a negedge monitor pops and compares on every done pulse.
module tb_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_op;
  logic [31:0] X;
  logic [31:0] Y;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  logic        overflow;

  divider #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
    .X(X), .Y(Y), .busy(busy), .done(done), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        ov;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference: plain integer division in 64-bit arithmetic (truncates toward zero)
  function automatic exp_t model(input bit sop, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    longint xs;
    longint ys;
    e.dz = 1'b0;
    e.ov = 1'b0;
    if (y == 32'd0) begin
      e.q  = 32'hFFFF_FFFF;
      e.r  = x;
      e.dz = 1'b1;
    end else if (sop) begin
      xs   = longint'($signed(x));
      ys   = longint'($signed(y));
      e.q  = 32'(xs / ys);
      e.r  = 32'(xs % ys);
      e.ov = (xs == -64'sd2147483648) && (ys == -64'sd1);
    end else begin
      e.q = x / y;
      e.r = x % y;
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got done=1 expected no pending operation at %0t", $time);
      end else begin
        e = sb.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("div_by_zero", div_by_zero, e.dz);
        check("overflow", overflow, e.ov);
      end
    end
  end

  task automatic run_op(input bit sop, input logic [31:0] x, input logic [31:0] y, input int pulse_at);
    exp_t ex;
    int   n;
    int   busy_n;
    int   lat;
    bit   seen;
    ex  = model(sop, x, y);
    lat = (y == 32'd0) ? 2 : 35;
    @(negedge clk);
    start     = 1'b1;
    signed_op = sop;
    X         = x;
    Y         = y;
    sb.push_back(ex);
    @(posedge clk);
    #1;
    start     = 1'b0;
    X         = $urandom;
    Y         = $urandom;
    signed_op = 1'($urandom);
    check("busy_after_start", busy, 1);
    n      = 0;
    busy_n = 0;
    seen   = 1'b0;
    while (!seen && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start = (n == pulse_at);
      if (done) seen = 1'b1;
      else if (busy) busy_n++;
    end
    start = 1'b0;
    if (!seen) begin
      check("done_timeout", n, lat);
      sb.delete();
      return;
    end
    check("latency", n, lat);
    check("busy_cycles", busy_n, lat - 1);
    @(negedge clk);
    check("done_single", done, 0);
    check("busy_idle", busy, 0);
    check("hold_quotient", quotient, ex.q);
    check("hold_remainder", remainder, ex.r);
  endtask

  initial begin
    logic [31:0] rx;
    logic [31:0] ry;
    int          sel;
    rst       = 1'b1;
    start     = 1'b0;
    signed_op = 1'b0;
    X         = '0;
    Y         = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dz", div_by_zero, 0);
    check("rst_ov", overflow, 0);
    @(negedge clk);
    rst = 1'b0;

    run_op(1'b1, 32'd7, 32'd2, -1);
    run_op(1'b1, -32'sd7, 32'd2, -1);
    run_op(1'b1, 32'd7, -32'sd2, -1);
    run_op(1'b0, 32'hFFFF_FFFF, 32'h10, -1);
    run_op(1'b1, 32'hFFFF_FFFF, 32'h10, -1);
    run_op(1'b0, 32'd100, 32'd0, -1);
    run_op(1'b0, 32'd9, 32'd3, -1);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    run_op(1'b0, 32'h8000_0000, 32'd1, -1);
    run_op(1'b1, 32'h8000_0000, 32'd0, -1);
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);

    // Restart attempt mid-operation must be ignored
    run_op(1'b0, 32'd50, 32'd7, 5);

    for (int i = 0; i < 40; i++) begin
      rx  = $urandom;
      ry  = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0: ry = 32'd0;
        1: ry = 32'hFFFF_FFFF;
        2: rx = 32'h8000_0000;
        3: begin rx = $urandom_range(0, 1000); ry = $urandom_range(1, 40); end
        4: ry = ry >> $urandom_range(0, 31);
        default: ;
      endcase
      run_op(1'($urandom), rx, ry, -1);
    end

    // Reset mid-operation aborts without a done pulse
    @(negedge clk);
    start     = 1'b1;
    signed_op = 1'b0;
    X         = 32'd1000;
    Y         = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_quotient", quotient, 0);
    check("abort_remainder", remainder, 0);
    check("abort_dz", div_by_zero, 0);
    check("abort_ov", overflow, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    run_op(1'b1, -32'sd1000, 32'd7, -1);

    repeat (5) @(negedge clk);
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL pending_results: got %0d outstanding expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
